// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for N common-anode 7-segment digits.
// One digit is selected per refresh slot; each slot starts with a short
// all-anodes-off blanking window to prevent ghosting, followed by the drive
// window. Displayed data is frame-buffered: a load only reaches the display
// at a frame boundary, which avoids torn updates. A load_ack pulse marks the
// moment a pending value becomes visible. Optional leading-zero suppression
// keeps high-order zero digits dark.

module seg7_scan_ctrl #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          load,
   input  logic [4*N_DIGITS-1:0]         value,
   input  logic [N_DIGITS-1:0]           dp_in,
   input  logic                          lz_en,
   output logic [3:0]                    hex_out,
   output logic [N_DIGITS-1:0]           anodes,
   output logic                          dp_out,
   output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
   output logic                          load_ack
);

   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int CNT_W = $clog2(REFRESH_DIV);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO      = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N_DIGITS - 1);

   logic [1:0]              state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        digit_idx_r;
   logic [4*N_DIGITS-1:0]   disp_r;
   logic [N_DIGITS-1:0]     disp_dp_r;
   logic [4*N_DIGITS-1:0]   pend_r;
   logic [N_DIGITS-1:0]     pend_dp_r;
   logic                    pend_valid_r;
   logic                    load_ack_r;

   logic [1:0]              state_nx_s;
   logic [CNT_W-1:0]        cnt_nx_s;
   logic [IDX_W-1:0]        idx_nx_s;
   logic                    frame_end_s;
   logic                    commit_s;
   logic [N_DIGITS-1:0]     supp_s;
   logic                    drive_on_s;

   // Slot sequencing: next state, slot counter and digit pointer.
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      idx_nx_s    = digit_idx_r;
      frame_end_s = 1'b0;
      if (!enable) begin
         state_nx_s = ST_OFF;
         cnt_nx_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ST_OFF: begin
               // Resume on the same digit, starting a fresh blanking window.
               state_nx_s = ST_BLANK;
               cnt_nx_s   = CNT_ZERO;
            end
            ST_BLANK: begin
               cnt_nx_s = cnt_r + CNT_ONE;
               if (cnt_r == CNT_BLANK_END) begin
                  state_nx_s = ST_DRIVE;
               end else begin
                  state_nx_s = ST_BLANK;
               end
            end
            ST_DRIVE: begin
               if (cnt_r == CNT_SLOT_END) begin
                  state_nx_s = ST_BLANK;
                  cnt_nx_s   = CNT_ZERO;
                  if (digit_idx_r == IDX_LAST) begin
                     idx_nx_s    = IDX_ZERO;
                     frame_end_s = 1'b1;
                  end else begin
                     idx_nx_s    = digit_idx_r + IDX_ONE;
                  end
               end else begin
                  cnt_nx_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_nx_s = ST_OFF;
               cnt_nx_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // A new value may become visible only at the end of a full frame or while dark.
   assign commit_s = (state_r == ST_OFF) || frame_end_s;

   // Scan state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_OFF;
         cnt_r       <= CNT_ZERO;
         digit_idx_r <= IDX_ZERO;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         digit_idx_r <= idx_nx_s;
      end
   end

   // Pending/display buffers; a load in a commit cycle stays pending for the next boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_r       <= {(4*N_DIGITS){1'b0}};
         disp_dp_r    <= {N_DIGITS{1'b0}};
         pend_r       <= {(4*N_DIGITS){1'b0}};
         pend_dp_r    <= {N_DIGITS{1'b0}};
         pend_valid_r <= 1'b0;
         load_ack_r   <= 1'b0;
      end else begin
         if (commit_s && pend_valid_r) begin
            disp_r       <= pend_r;
            disp_dp_r    <= pend_dp_r;
            pend_valid_r <= 1'b0;
            load_ack_r   <= 1'b1;
         end else begin
            load_ack_r   <= 1'b0;
         end
         if (load) begin
            pend_r       <= value;
            pend_dp_r    <= dp_in;
            pend_valid_r <= 1'b1;
         end
      end
   end

   // Leading-zero suppression: walk down from the top digit while nibbles are zero.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      supp_s   = {N_DIGITS{1'b0}};
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_r[4*i +: 4] == 4'h0);
         if ((i > 0) && lz_en && zero_run && !disp_dp_r[i]) begin
            supp_s[i] = 1'b1;
         end else begin
            supp_s[i] = 1'b0;
         end
      end
   end

   assign drive_on_s = (state_r == ST_DRIVE) && !supp_s[digit_idx_r];

   // Digit drive: the selected anode and its decimal point are lit only while driving.
   always_comb begin
      hex_out = disp_r[{digit_idx_r, 2'b00} +: 4];
      anodes  = {N_DIGITS{1'b1}};
      dp_out  = 1'b1;
      if (drive_on_s) begin
         anodes[digit_idx_r] = 1'b0;
         dp_out              = ~disp_dp_r[digit_idx_r];
      end else begin
         anodes = {N_DIGITS{1'b1}};
         dp_out = 1'b1;
      end
   end

   assign digit_idx = digit_idx_r;
   assign load_ack  = load_ack_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// A reference model tracks the frame position as a single counter and the
// buffers as plain variables; each cycle it queues the expected outputs, and
// an independent monitor pops and compares them against the DUT.

module tb_seg7_scan_ctrl;

   localparam int N  = 4;
   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FR = N * RD;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic [3:0]  hex_out;
   logic [3:0]  anodes;
   logic        dp_out;
   logic [1:0]  digit_idx;
   logic        load_ack;

   seg7_scan_ctrl #(
      .N_DIGITS    (N),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .load     (load),
      .value    (value),
      .dp_in    (dp_in),
      .lz_en    (lz_en),
      .hex_out  (hex_out),
      .anodes   (anodes),
      .dp_out   (dp_out),
      .digit_idx(digit_idx),
      .load_ack (load_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] hex;
      logic [3:0] an;
      logic       dp;
      logic [1:0] idx;
      logic       ack;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   // Reference model state
   bit          m_on;
   int          m_pos;
   logic [15:0] m_disp;
   logic [15:0] m_pend;
   logic [3:0]  m_dp;
   logic [3:0]  m_pend_dp;
   bit          m_pv;
   bit          m_ack;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position pos = digit*RD + slot offset.
   always @(posedge clk) begin : model
      exp_t e;
      bit   commit;
      int   d;
      bit   lit;
      if (reset) begin
         m_on = 1'b0; m_pos = 0; m_disp = 16'h0; m_dp = 4'h0;
         m_pend = 16'h0; m_pend_dp = 4'h0; m_pv = 1'b0; m_ack = 1'b0;
      end else begin
         commit = !m_on || (enable && m_pos == FR - 1);
         if (commit && m_pv) begin
            m_disp = m_pend; m_dp = m_pend_dp; m_pv = 1'b0; m_ack = 1'b1;
         end else begin
            m_ack = 1'b0;
         end
         if (load) begin
            m_pend = value; m_pend_dp = dp_in; m_pv = 1'b1;
         end
         if (!enable) begin
            m_on  = 1'b0;
            m_pos = (m_pos / RD) * RD;
         end else if (!m_on) begin
            m_on = 1'b1;
         end else begin
            m_pos = (m_pos + 1) % FR;
         end
      end
      d   = m_pos / RD;
      lit = m_on && ((m_pos % RD) >= BC) &&
            !(lz_en && d > 0 && ((m_disp >> (4 * d)) == 16'h0) && !m_dp[d]);
      e.hex = m_disp[4*d +: 4];
      e.an  = lit ? ~(4'b0001 << d) : 4'b1111;
      e.dp  = lit ? ~m_dp[d] : 1'b1;
      e.idx = 2'(d);
      e.ack = m_ack;
      exp_q.push_back(e);
   end

   // Monitor: compare DUT outputs shortly after every rising edge.
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         chk("hex_out",   {12'h0, hex_out},   {12'h0, e.hex});
         chk("anodes",    {12'h0, anodes},    {12'h0, e.an});
         chk("dp_out",    {15'h0, dp_out},    {15'h0, e.dp});
         chk("digit_idx", {14'h0, digit_idx}, {14'h0, e.idx});
         chk("load_ack",  {15'h0, load_ack},  {15'h0, e.ack});
      end
   end

   task automatic wait_pos(input int target);
      int n;
      n = 0;
      while (!(m_on && m_pos == target) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         $display("FAIL wait_pos: got timeout, required position %0d", target);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load  = 1'b1;
      value = v;
      dp_in = d;
      @(negedge clk);
      load  = 1'b0;
   endtask

   initial begin
      logic [15:0] v;
      reset = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; lz_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Scan order with 0x4321 committed while dark
      do_load(16'h4321, 4'h0);
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (40) @(negedge clk);

      // Tear-free load during digit 1 drive
      wait_pos(RD + BC + 1);
      do_load(16'hBEEF, 4'h0);
      repeat (70) @(negedge clk);

      // Load coinciding with the commit edge
      wait_pos(20);
      do_load(16'h1111, 4'h0);
      wait_pos(FR - 1);
      do_load(16'h2222, 4'h0);
      repeat (70) @(negedge clk);

      // Leading-zero suppression
      lz_en = 1'b1;
      do_load(16'h0040, 4'h0);
      repeat (70) @(negedge clk);
      do_load(16'h0000, 4'h0);
      repeat (70) @(negedge clk);
      do_load(16'h0040, 4'b0100);
      repeat (70) @(negedge clk);
      lz_en = 1'b0;

      // Enable drop on digit 2, commit while off, resume
      wait_pos(2 * RD + 4);
      enable = 1'b0;
      @(negedge clk);
      do_load(16'h5A5A, 4'b1001);
      repeat (3) @(negedge clk);
      enable = 1'b1;
      repeat (40) @(negedge clk);

      // Asynchronous reset mid-drive discards a pending value
      wait_pos(RD + 5);
      do_load(16'h9999, 4'h0);
      reset = 1'b1;
      #1;
      chk("rst_anodes",    {12'h0, anodes},    16'h000F);
      chk("rst_dp_out",    {15'h0, dp_out},    16'h0001);
      chk("rst_digit_idx", {14'h0, digit_idx}, 16'h0000);
      chk("rst_load_ack",  {15'h0, load_ack},  16'h0000);
      chk("rst_hex_out",   {12'h0, hex_out},   16'h0000);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      enable = 1'b1;

      // Randomized traffic
      for (int k = 0; k < 2000; k++) begin
         enable = ($urandom_range(0, 99) < 94);
         if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
         if ($urandom_range(0, 7) == 0) begin
            v = 16'($urandom);
            for (int j = 0; j < 4; j++) begin
               if ($urandom_range(0, 1) == 1) v[4*j +: 4] = 4'h0;
            end
            load  = 1'b1;
            value = v;
            dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         end else begin
            load = 1'b0;
         end
         reset = ($urandom_range(0, 399) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      load  = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
